spike_event_arbiter: RTL and testbench

Round-robin arbiter that collects single-cycle spike pulses from a bank of `neuron` instances and serialises them into one indexed event stream with a valid/ready handshake. It sits between the oscillator neuron array and any shared downstream consumer, such as a coupling/weight-update unit or an output encoder. That consumer can accept at most one spike event per cycle. Each neuron is granted fairly, per-neuron enables are honoured, and stalled output never loses the event currently presented.

---
 rtl/spike_event_arbiter_if.sv | 63 ++++++
 rtl/spike_event_arbiter.sv | 159 +++++++++++++++
 tb/tb_spike_event_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_event_arbiter_if.sv
// spike_event_arbiter_if
//   Bundles the spike inputs, the enable mask, and the indexed event stream
//   (valid/ready handshake) that leave the spike_event_arbiter.
//
//   Optional feature macro: SPIKE_DROP_CNT_EN.
//   When it is defined, the interface also carries drop_cnt.
//
//   Signals:
//     spike_in  [N_NEURONS] : per-neuron single-cycle spike pulses
//     mask      [N_NEURONS] : 1 = neuron enabled for new spikes
//     evt_valid             : event presented on evt_idx
//     evt_ready             : consumer accepts the presented event this cycle
//     evt_idx   [IDX_W]     : index of the presented neuron
//     pending   [N_NEURONS] : latched spikes not yet granted
//     busy                  : an event is presented or a spike is pending
//     drop_cnt  [DROP_W]    : saturating count of merged spikes (macro only)
//
//   Modports:
//     master : the arbiter side
//     slave  : the neuron array and the consumer side
interface spike_event_arbiter_if #(
    parameter int N_NEURONS = 8,
    parameter int DROP_W    = 8
);
    localparam int IDX_W = $clog2(N_NEURONS);

    logic [N_NEURONS-1:0] spike_in;
    logic [N_NEURONS-1:0] mask;
    logic                 evt_valid;
    logic                 evt_ready;
    logic [IDX_W-1:0]     evt_idx;
    logic [N_NEURONS-1:0] pending;
    logic                 busy;

    if (DROP_W < 1) begin : g_bad_drop_w
        $error("spike_event_arbiter_if: DROP_W must be at least 1");
    end

`ifdef SPIKE_DROP_CNT_EN
    logic [DROP_W-1:0]    drop_cnt;

    modport master (
        input  spike_in, mask, evt_ready,
        output evt_valid, evt_idx, pending, busy, drop_cnt
    );

    modport slave (
        output spike_in, mask, evt_ready,
        input  evt_valid, evt_idx, pending, busy, drop_cnt
    );
`else
    modport master (
        input  spike_in, mask, evt_ready,
        output evt_valid, evt_idx, pending, busy
    );

    modport slave (
        output spike_in, mask, evt_ready,
        input  evt_valid, evt_idx, pending, busy
    );
`endif

endinterface

// File: rtl/spike_event_arbiter.sv
// spike_event_arbiter
//   Round-robin arbiter that latches single-cycle spike pulses from a bank of
//   neurons. It serialises them into one indexed event stream that a
//   downstream consumer drains at up to one event per cycle.
//
//   Optional feature macro: SPIKE_DROP_CNT_EN.
//   When it is defined, a saturating counter reports the spikes that were
//   merged into an already pending bit.
//
//   Parameters:
//     N_NEURONS : number of spike inputs (2..16, any value)
//     DROP_W    : width of the dropped-spike counter
//
//   Ports:
//     clk    : single clock, all state updates on the rising edge
//     reset  : synchronous, active-high
//     bus    : spike_event_arbiter_if.master
//              (spike_in, mask, evt_ready in)
//              (evt_valid, evt_idx, pending, busy, [drop_cnt] out)
module spike_event_arbiter #(
    parameter int N_NEURONS = 8,
    parameter int DROP_W    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    spike_event_arbiter_if.master   bus
);

    localparam int              IDX_W    = $clog2(N_NEURONS);
    localparam logic [IDX_W:0]  N_CAND   = (IDX_W+1)'(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    if (N_NEURONS < 2 || N_NEURONS > 16) begin : g_bad_n
        $error("spike_event_arbiter: N_NEURONS must be in 2..16");
    end
    if (DROP_W < 1) begin : g_bad_drop_w
        $error("spike_event_arbiter: DROP_W must be at least 1");
    end

    logic [N_NEURONS-1:0] pending_q;
    logic [N_NEURONS-1:0] pending_d;
    logic [N_NEURONS-1:0] spike_cap;
    logic [N_NEURONS-1:0] grant_onehot;
    logic                 evt_valid_q;
    logic [IDX_W-1:0]     evt_idx_q;
    logic [IDX_W-1:0]     rr_ptr_q;
    logic [IDX_W-1:0]     grant_idx;
    logic                 grant_found;
    logic                 slot_free;
    logic                 grant_fire;
    logic [IDX_W:0]       cand;

    // The mask gates only newly arriving spikes.
    // Bits already latched in pending survive a mask drop.
    assign spike_cap = bus.spike_in & bus.mask;

    // The slot can take a new event when nothing is shown or the shown one
    // is being accepted right now. This keeps back-to-back grants bubble-free.
    assign slot_free  = !evt_valid_q || bus.evt_ready;
    assign grant_fire = slot_free && grant_found;

    // Circular search for the first pending bit at or above rr_ptr.
    // A one-bit-wider candidate index wraps without needing a power-of-two
    // neuron count.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= N_CAND) begin
                cand = cand - N_CAND;
            end
            if (!grant_found && pending_q[cand[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // The granted bit is cleared before new captures are ORed in.
    // A re-spike on the granted neuron in the same cycle therefore re-arms it.
    always_comb begin
        grant_onehot = '0;
        if (grant_fire) begin
            grant_onehot[grant_idx] = 1'b1;
        end
        pending_d = (pending_q & ~grant_onehot) | spike_cap;
    end

    // Pending bits, the presented event and the round-robin pointer.
    // All three hold while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_idx_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            pending_q <= pending_d;
            if (slot_free) begin
                if (grant_found) begin
                    evt_valid_q <= 1'b1;
                    evt_idx_q   <= grant_idx;
                    rr_ptr_q    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end else begin
                    evt_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_idx   = evt_idx_q;
    assign bus.pending   = pending_q;
    assign bus.busy      = evt_valid_q | (|pending_q);

`ifdef SPIKE_DROP_CNT_EN
    localparam int SUM_W = DROP_W + 5;

    logic [N_NEURONS-1:0] drop_vec;
    logic [4:0]           drop_num;
    logic [SUM_W-1:0]     drop_sum;
    logic [DROP_W-1:0]    drop_cnt_q;
    logic [DROP_W-1:0]    drop_cnt_d;

    // A drop is a capture on a bit that is already pending and is not being
    // granted this cycle. A spike on the currently presented neuron only
    // counts if that neuron is also pending again.
    assign drop_vec = spike_cap & pending_q & ~grant_onehot;

    // Several neurons can drop in one cycle.
    // The sum is formed wide and then clamped so the counter never wraps.
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            drop_num = drop_num + 5'(drop_vec[i]);
        end
        drop_sum = SUM_W'(drop_cnt_q) + SUM_W'(drop_num);
        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    // Counter register; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_event_arbiter.sv
// tb_spike_event_arbiter
//   Self-checking bench for spike_event_arbiter with N_NEURONS=8, DROP_W=2.
//   Expected event indices are queued when spikes are driven. A negedge
//   monitor pops and compares one entry for every accepted event.
//   Drop counter checks exist only when SPIKE_DROP_CNT_EN is defined.
module tb_spike_event_arbiter;

    localparam int N  = 8;
    localparam int DW = 2;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    spike_event_arbiter_if #(.N_NEURONS(N), .DROP_W(DW)) bus ();

    spike_event_arbiter #(.N_NEURONS(N), .DROP_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int exp_q[$];

    // Single comparison point for the whole bench.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    // Drive inputs just after the active edge.
    task automatic apply_stimulus(input logic [N-1:0] spike, input logic [N-1:0] msk,
                                  input logic rdy);
        bus.spike_in  = spike;
        bus.mask      = msk;
        bus.evt_ready = rdy;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        apply_stimulus('0, 8'hFF, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard: an event is consumed at the next edge whenever valid and
    // ready are both high mid-cycle.
    always @(negedge clk) begin
        if (!reset && bus.evt_valid && bus.evt_ready) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_evt", bus.evt_idx, 32'hFFFF_FFFF);
            end else begin
                check_output("sb_evt_idx", bus.evt_idx, exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        apply_stimulus('0, 8'hFF, 1'b0);
        tick();
        check_output("rst_valid",   bus.evt_valid, 0);
        check_output("rst_idx",     bus.evt_idx,   0);
        check_output("rst_pending", bus.pending,   0);
        check_output("rst_busy",    bus.busy,      0);
`ifdef SPIKE_DROP_CNT_EN
        check_output("rst_drop",    bus.drop_cnt,  0);
`endif
        reset = 1'b0;

        // Single spike on neuron 3: presented exactly two edges later.
        do_reset();
        exp_q.push_back(3);
        apply_stimulus(8'h08, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        check_output("single_pend",   bus.pending,   8'h08);
        check_output("single_early",  bus.evt_valid, 0);
        tick();
        check_output("single_valid",  bus.evt_valid, 1);
        check_output("single_idx",    bus.evt_idx,   3);
        tick();
        check_output("single_done",   bus.evt_valid, 0);
        check_output("single_busy",   bus.busy,      0);

        // All eight at once: consecutive grants 0..7, then 0 and 7 after wrap.
        do_reset();
        for (int i = 0; i < N; i++) exp_q.push_back(i);
        apply_stimulus(8'hFF, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        for (int i = 0; i < N; i++) begin
            tick();
            check_output($sformatf("rr_valid%0d", i), bus.evt_valid, 1);
            check_output($sformatf("rr_idx%0d", i),   bus.evt_idx,   i);
        end
        tick();
        check_output("rr_idle", bus.evt_valid, 0);
        exp_q.push_back(0);
        exp_q.push_back(7);
        apply_stimulus(8'h81, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick();
        check_output("wrap_idx0", bus.evt_idx, 0);
        tick();
        check_output("wrap_idx7", bus.evt_idx, 7);
        tick();
        check_output("wrap_busy", bus.busy, 0);

        // Backpressure: neuron 0 held while 2 waits, then drained in order.
        do_reset();
        apply_stimulus(8'h05, 8'hFF, 1'b0);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_output("bp_valid", bus.evt_valid, 1);
            check_output("bp_idx",   bus.evt_idx,   0);
            check_output("bp_pend",  bus.pending,   8'h04);
        end
        exp_q.push_back(0);
        exp_q.push_back(2);
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick();
        check_output("bp_next_idx",   bus.evt_idx,   2);
        check_output("bp_next_valid", bus.evt_valid, 1);
        tick();
        check_output("bp_done", bus.evt_valid, 0);

        // Repeated spikes on a stalled pending neuron 5.
        do_reset();
        apply_stimulus(8'h20, 8'hFF, 1'b0);
        tick();
        tick();
        check_output("drop_first_idx", bus.evt_idx, 5);
        check_output("drop_first_pend", bus.pending, 8'h20);
`ifdef SPIKE_DROP_CNT_EN
        check_output("drop_respike0", bus.drop_cnt, 0);
`endif
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_output("drop_hold_pend", bus.pending, 8'h20);
`ifdef SPIKE_DROP_CNT_EN
            check_output($sformatf("drop_cnt%0d", k), bus.drop_cnt, (k > 3) ? 3 : k);
`endif
        end

        // Neurons 5 and 6 dropping together, then drained 5,6,5.
        do_reset();
        apply_stimulus(8'h60, 8'hFF, 1'b0);
        tick();
        tick();
        check_output("pair_idx",  bus.evt_idx, 5);
        check_output("pair_pend", bus.pending, 8'h60);
`ifdef SPIKE_DROP_CNT_EN
        check_output("pair_drop1", bus.drop_cnt, 1);
`endif
        tick();
`ifdef SPIKE_DROP_CNT_EN
        check_output("pair_drop3", bus.drop_cnt, 3);
`endif
        exp_q.push_back(5);
        exp_q.push_back(6);
        exp_q.push_back(5);
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick(3);
        check_output("pair_done",  bus.busy, 0);
        check_output("pair_q",     exp_q.size(), 0);
`ifdef SPIKE_DROP_CNT_EN
        check_output("pair_sat",   bus.drop_cnt, 3);
`endif

        // Re-spike on neuron 2 in the cycle it is granted.
        do_reset();
        exp_q.push_back(2);
        exp_q.push_back(2);
        apply_stimulus(8'h04, 8'hFF, 1'b1);
        tick();
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        check_output("respike_idx",  bus.evt_idx, 2);
        check_output("respike_pend", bus.pending, 8'h04);
`ifdef SPIKE_DROP_CNT_EN
        check_output("respike_drop", bus.drop_cnt, 0);
`endif
        tick();
        check_output("respike_again", bus.evt_idx,   2);
        check_output("respike_val",   bus.evt_valid, 1);
        check_output("respike_clr",   bus.pending,   0);
        tick();
        check_output("respike_done",  bus.evt_valid, 0);

        // Masked neuron 4: nothing captured, nothing counted.
        apply_stimulus(8'h10, 8'hEF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        check_output("mask_pend", bus.pending, 0);
        tick();
        check_output("mask_valid", bus.evt_valid, 0);
        check_output("mask_busy",  bus.busy,      0);
`ifdef SPIKE_DROP_CNT_EN
        check_output("mask_drop",  bus.drop_cnt,  0);
`endif

        // Mask dropping after capture leaves the pending bit in place.
        do_reset();
        apply_stimulus(8'h11, 8'hFF, 1'b0);
        tick();
        apply_stimulus(8'h00, 8'h00, 1'b0);
        tick();
        check_output("mask_keep_idx",  bus.evt_idx, 0);
        check_output("mask_keep_pend", bus.pending, 8'h10);

        // Reset mid-operation with spikes and ready driven during reset.
        do_reset();
        apply_stimulus(8'hF0, 8'hFF, 1'b0);
        tick(2);
        check_output("mid_pend",  bus.pending,   8'hF0);
        check_output("mid_valid", bus.evt_valid, 1);
        check_output("mid_idx",   bus.evt_idx,   4);
        reset = 1'b1;
        exp_q.delete();
        apply_stimulus(8'hFF, 8'hFF, 1'b1);
        tick();
        reset = 1'b0;
        check_output("mid_rst_valid", bus.evt_valid, 0);
        check_output("mid_rst_idx",   bus.evt_idx,   0);
        check_output("mid_rst_pend",  bus.pending,   0);
        check_output("mid_rst_busy",  bus.busy,      0);
`ifdef SPIKE_DROP_CNT_EN
        check_output("mid_rst_drop",  bus.drop_cnt,  0);
`endif
        exp_q.push_back(6);
        apply_stimulus(8'h40, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick();
        check_output("post_rst_idx",   bus.evt_idx,   6);
        check_output("post_rst_valid", bus.evt_valid, 1);
        tick();
        check_output("post_rst_done",  bus.evt_valid, 0);

        // Pointer left at 6 must restart at 0 after reset: 1 wins over 6.
        do_reset();
        apply_stimulus(8'h20, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b0);
        exp_q.push_back(5);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick();
        do_reset();
        exp_q.push_back(1);
        exp_q.push_back(6);
        apply_stimulus(8'h42, 8'hFF, 1'b1);
        tick();
        apply_stimulus(8'h00, 8'hFF, 1'b1);
        tick();
        check_output("rrrst_idx1", bus.evt_idx, 1);
        tick();
        check_output("rrrst_idx6", bus.evt_idx, 6);
        tick();
        check_output("rrrst_busy", bus.busy, 0);
        check_output("final_q",    exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
